// File: rtl/moving_avg_pkg.sv
// Shared helpers for the moving-average filter: width derivation,
// a constant-friendly clog2 and the window-select clamp.
package moving_avg_pkg;

  // Smallest r with 2^r >= value (0 for value <= 1).
  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: enough headroom for 2^log2_depth full-scale samples.
  function automatic int calc_sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Effective window exponent: selections beyond the history depth clamp.
  function automatic int eff_k(input int sel, input int max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running sample-tick generator: one-cycle tick every TICK_DIV clocks.
// Only reset clears the count, so window flushes do not shift the tick phase.
module tick_divider
  import moving_avg_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (clog2_int(TICK_DIV) < 1) ? 1 : clog2_int(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  // Count 0..TICK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/moving_avg_filter.sv
// Boxcar averager over a run-time power-of-two window. A circular history
// feeds a running sum: each tick adds the new sample and removes the one
// falling out of the window. Changing the window restarts the average.
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int MAX_LOG2_DEPTH = 4,
  parameter int TICK_DIV       = 500000,
  parameter int SEL_W          = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         win_sel,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     primed
);

  localparam int DEPTH = 1 << MAX_LOG2_DEPTH;
  localparam int SUM_W = calc_sum_w(DATA_W, MAX_LOG2_DEPTH);
  localparam int K_W   = (clog2_int(MAX_LOG2_DEPTH + 1) < 1) ? 1 : clog2_int(MAX_LOG2_DEPTH + 1);

  logic tick;

  logic signed [DATA_W-1:0]   hist [DEPTH];
  logic [MAX_LOG2_DEPTH-1:0]  wr;
  logic [MAX_LOG2_DEPTH-1:0]  rd_idx;
  logic [MAX_LOG2_DEPTH:0]    fill;
  logic [MAX_LOG2_DEPTH:0]    fill_next;
  logic [MAX_LOG2_DEPTH:0]    win_len;
  logic [K_W-1:0]             k_q;
  logic [K_W-1:0]             k_eff;
  logic                       flush;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    sum_next;
  logic signed [SUM_W-1:0]    in_ext;
  logic signed [SUM_W-1:0]    old_ext;
  logic signed [DATA_W-1:0]   avg_next;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign k_eff = K_W'(eff_k(int'(win_sel), MAX_LOG2_DEPTH));
  assign flush = (k_eff != k_q);

  // Window length 2^k; for the full window the low bits vanish so the
  // sample leaving the window is the one about to be overwritten.
  assign win_len   = {{MAX_LOG2_DEPTH{1'b0}}, 1'b1} << k_q;
  assign rd_idx    = wr - win_len[MAX_LOG2_DEPTH-1:0];
  assign in_ext    = SUM_W'(in_data);
  assign old_ext   = SUM_W'(hist[rd_idx]);
  assign sum_next  = sum + in_ext - old_ext;
  assign avg_next  = DATA_W'(sum_next >>> k_q);
  assign fill_next = (fill == win_len) ? fill : fill + 1'b1;
  assign primed    = (fill == win_len);

  // Reset and window change share one clear path; otherwise advance on tick.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      k_q       <= k_eff;
      wr        <= '0;
      fill      <= '0;
      sum       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      out_valid <= tick;
      if (tick) begin
        hist[wr] <= in_data;
        wr       <= wr + 1'b1;
        sum      <= sum_next;
        fill     <= fill_next;
        out_data <= avg_next;
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter with a window-sum reference model
// and an expected-value scoreboard popped on each out_valid pulse.
module tb_moving_avg_filter;

  localparam int DATA_W = 16;
  localparam int MAXL   = 4;
  localparam int TDIV   = 4;
  localparam int SEL_W  = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]         win_sel;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     primed;

  int n_cmp = 0;
  int n_bad = 0;

  int samples[$];
  int exp_q[$];
  bit prm_q[$];
  int k_m;

  moving_avg_filter #(
    .DATA_W(DATA_W), .MAX_LOG2_DEPTH(MAXL), .TICK_DIV(TDIV), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .win_sel(win_sel),
    .out_data(out_data), .out_valid(out_valid), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_flush(input int k);
    samples.delete();
    k_m = (k > MAXL) ? MAXL : k;
  endfunction

  // Reference: floor of the sum of the last 2^k samples (missing = 0) / 2^k.
  function automatic void push_expected(input int v);
    int s;
    int n;
    int w;
    s = 0;
    w = 1 << k_m;
    samples.push_back(v);
    n = samples.size();
    for (int i = 0; i < w && i < n; i++) s += samples[n-1-i];
    exp_q.push_back(s >>> k_m);
    prm_q.push_back(n >= w);
  endfunction

  task automatic do_reset(input int sel);
    win_sel = SEL_W'(sel);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_flush(sel);
  endtask

  // Present one sample, wait for its result, compare, and check pulse width.
  task automatic do_tick(input string tag, input int v, output int got);
    int  e;
    bit  p;
    int  seen;
    in_data = DATA_W'(v);
    push_expected(v);
    seen = 0;
    got  = 0;
    for (int c = 0; c < 2 * TDIV && seen == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    check({tag, "_valid_seen"}, seen, 1);
    e = exp_q.pop_front();
    p = prm_q.pop_front();
    if (seen != 0) begin
      got = int'($signed(out_data));
      check({tag, "_data"}, $signed(out_data), e);
      check({tag, "_primed"}, primed, p);
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, out_valid, 0);
    end
  endtask

  initial begin
    int g;
    int prev;
    int lat;
    int step_exp[5];
    int neg_exp[2];
    step_exp = '{25, 50, 75, 100, 100};
    neg_exp  = '{-2, -4};
    reset   = 1'b1;
    in_data = '0;
    win_sel = '0;
    @(posedge clk); #1;

    // Reset state
    do_reset(0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_primed", primed, 0);

    // Passthrough
    do_tick("pass0", 5, g);
    check("pass0_tab", g, 5);
    do_tick("pass1", -7, g);
    check("pass1_tab", g, -7);
    do_tick("pass2", 32767, g);
    check("pass2_tab", g, 32767);

    // Step response, window 4
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      do_tick("step", 100, g);
      check("step_tab", g, step_exp[i]);
    end

    // Window change on the tick cycle: flush wins, sample dropped
    @(posedge clk); #1;
    @(posedge clk); #1;
    win_sel = 3'd3;
    in_data = 16'sd999;
    @(posedge clk); #1;
    check("wchg_out_data", $signed(out_data), 0);
    check("wchg_primed", primed, 0);
    check("wchg_out_valid", out_valid, 0);
    model_flush(3);
    for (int i = 0; i < 8; i++) begin
      do_tick("wchg", 80, g);
      check("wchg_tab", g, 10 * (i + 1));
    end

    // Negative rounding toward -inf
    do_reset(1);
    do_tick("neg0", -3, g);
    check("neg0_tab", g, neg_exp[0]);
    do_tick("neg1", -4, g);
    check("neg1_tab", g, neg_exp[1]);

    // Full window, clamped selections, extremes
    do_reset(4);
    do_tick("ext_pos", 32767, g);
    win_sel = 3'd7;
    @(posedge clk); #1;
    win_sel = 3'd5;
    @(posedge clk); #1;
    check("clamp_noflush", $signed(out_data), 2047);
    for (int i = 1; i < 16; i++) do_tick("ext_pos", 32767, g);
    check("ext_pos_last", g, 32767);
    prev = g;
    for (int i = 0; i < 16; i++) begin
      do_tick("ext_neg", -32768, g);
      check("ext_neg_mono", (g < prev) ? 1 : 0, 1);
      prev = g;
    end
    check("ext_neg_last", g, -32768);

    // Reset between ticks
    win_sel = 3'd2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_data", $signed(out_data), 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_primed", primed, 0);
    reset = 1'b0;
    model_flush(2);
    in_data = 16'sd40;
    push_expected(40);
    lat = 0;
    for (int n = 1; n <= 3 * TDIV && lat == 0; n++) begin
      if (out_valid === 1'b1) lat = n;
      else begin
        @(posedge clk); #1;
      end
    end
    check("mid_rst_latency", lat, TDIV + 1);
    check("mid_rst_data", $signed(out_data), exp_q.pop_front());
    check("mid_rst_primed_after", primed, prm_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
